// File: rtl/keypad_grid_select_if.sv
// Keypad-side and result signals of keypad_grid_select bundled as one port.
// The slave modport is the decoder; the master modport is the keypad/consumer side.
interface keypad_grid_select_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            mode;
  logic            clear;
  logic [KW-1:0]   key;
  logic            key_valid;
  logic            key_held;
  logic [N-1:0]    value;

  modport slave (
    input  row, mode, clear,
    output col, key, key_valid, key_held, value
  );

  modport master (
    output row, mode, clear,
    input  col, key, key_valid, key_held, value
  );
endinterface

// File: rtl/keypad_grid_select.sv
// Scans a ROWS x COLS keypad, debounces whole frames and keeps a select/toggle cell
// vector. Define KEYPAD_REPEAT_EN to add auto-repeat of a held key every REPEAT_FRAMES.
module keypad_grid_select #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 32
) (
  input logic                 clk,
  input logic                 reset,
  keypad_grid_select_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [BW-1:0] CNT_MAX  = BW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] { CLS_NONE, CLS_KEY, CLS_MULTI } cls_e;

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("keypad_grid_select: need SCAN_DIV >= 2, DEBOUNCE_SCANS >= 1, REPEAT_FRAMES >= 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;   // pressed cells so far this frame: 0, 1, 2 = two or more
  logic [KW-1:0] acc_key_q, acc_key_d;
  cls_e          prev_cls_q, prev_cls_d;
  logic [KW-1:0] prev_key_q, prev_key_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [N-1:0]  value_q, value_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int PW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [PW-1:0] REP_LAST = PW'(REPEAT_FRAMES - 1);
  logic [PW-1:0] rep_q, rep_d;
  logic [N-1:0]  held_onehot;
  assign held_onehot = N'(1) << key_q;
`endif

  logic          sample, frame_end;
  logic [1:0]    col_hits;
  logic [RW-1:0] col_row;
  logic [1:0]    merged_cnt;
  logic [KW-1:0] merged_key;
  cls_e          frame_cls;
  logic [N-1:0]  key_onehot;
  logic          accept_press, accept_release;

  assign sample     = (div_q == DIV_LAST);
  assign frame_end  = sample && (col_idx_q == COL_LAST);
  assign key_onehot = N'(1) << merged_key;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.row[r]) begin
        if (col_hits == 2'd0) col_row = RW'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  // Fold the current column into the frame accumulator.
  always_comb begin
    if (acc_cnt_q == 2'd2 || col_hits == 2'd2 || (acc_cnt_q == 2'd1 && col_hits == 2'd1)) begin
      merged_cnt = 2'd2;
    end else begin
      merged_cnt = acc_cnt_q | col_hits;
    end
    merged_key = (acc_cnt_q == 2'd1) ? acc_key_q
                                     : KW'(int'(col_idx_q) * ROWS + int'(col_row));
    unique case (merged_cnt)
      2'd0:    frame_cls = CLS_NONE;
      2'd1:    frame_cls = CLS_KEY;
      default: frame_cls = CLS_MULTI;
    endcase
  end

  always_comb begin
    div_d          = div_q + 1'b1;
    col_idx_d      = col_idx_q;
    acc_cnt_d      = acc_cnt_q;
    acc_key_d      = acc_key_q;
    prev_cls_d     = prev_cls_q;
    prev_key_d     = prev_key_q;
    cnt_d          = cnt_q;
    key_d          = key_q;
    key_valid_d    = 1'b0;
    key_held_d     = key_held_q;
    value_d        = value_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d          = rep_q;
`endif

    if (sample) begin
      div_d     = '0;
      col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
      if (!frame_end) begin
        acc_cnt_d = merged_cnt;
        acc_key_d = merged_key;
      end else begin
        acc_cnt_d  = 2'd0;
        acc_key_d  = '0;
        prev_cls_d = frame_cls;
        prev_key_d = merged_key;
        if (frame_cls == CLS_MULTI) begin
          cnt_d = '0;
        end else if (frame_cls == prev_cls_q &&
                     (frame_cls == CLS_NONE || merged_key == prev_key_q)) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cnt_d = BW'(1);
        end

        accept_press   = (cnt_d == CNT_MAX) && (frame_cls == CLS_KEY) &&
                         (!key_held_q || merged_key != key_q);
        accept_release = (cnt_d == CNT_MAX) && (frame_cls == CLS_NONE) && key_held_q;

        if (accept_press) begin
          key_d       = merged_key;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          value_d     = bus.mode ? (value_q ^ key_onehot) : key_onehot;
        end else if (accept_release) begin
          key_held_d = 1'b0;
        end

`ifdef KEYPAD_REPEAT_EN
        // Repeats re-announce the held key; toggle mode must not flip the cell again.
        if (accept_press || accept_release) begin
          rep_d = '0;
        end else if (key_held_q) begin
          if (rep_q == REP_LAST) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
            if (!bus.mode) value_d = held_onehot;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
    end

    if (bus.clear) value_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      col_idx_q   <= '0;
      acc_cnt_q   <= 2'd0;
      acc_key_q   <= '0;
      prev_cls_q  <= CLS_NONE;
      prev_key_q  <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      value_q     <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_key_q   <= acc_key_d;
      prev_cls_q  <= prev_cls_d;
      prev_key_q  <= prev_key_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      value_q     <= value_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign bus.col       = ~(COLS'(1) << col_idx_q);
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.value     = value_q;
endmodule

// File: tb/tb_keypad_grid_select.sv
// Directed bench for keypad_grid_select: 4x4 pad, SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
// A small keypad model pulls row[r] low while column c is driven and cell c*4+r is pressed.
module tb_keypad_grid_select;
  localparam int ROWS           = 4;
  localparam int COLS           = 4;
  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int REPEAT_FRAMES  = 3;
  localparam int FRAME          = COLS * SCAN_DIV;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_PULSES = 4;
`else
  localparam int HOLD_PULSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pressed;
  logic [3:0]  row_drv;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;

  keypad_grid_select_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  keypad_grid_select #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS), .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_drv = 4'hF;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!bus.col[c] && pressed[c*ROWS+r]) row_drv[r] = 1'b0;
      end
    end
  end
  assign bus.row = row_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.key_valid === 1'b1) pulses++;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  initial begin
    reset      = 1'b1;
    pressed    = 16'h0000;
    bus.mode   = 1'b0;
    bus.clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state and idle column walk.
    check("reset_col",       32'(bus.col),       32'h0000_000E);
    check("reset_key",       32'(bus.key),       32'h0);
    check("reset_key_valid", 32'(bus.key_valid), 32'h0);
    check("reset_key_held",  32'(bus.key_held),  32'h0);
    check("reset_value",     32'(bus.value),     32'h0);
    repeat (3) tick();
    check("col0_still", 32'(bus.col), 32'h0000_000E);
    tick();
    check("col1", 32'(bus.col), 32'h0000_000D);
    repeat (4) tick();
    check("col2", 32'(bus.col), 32'h0000_000B);
    repeat (4) tick();
    check("col3", 32'(bus.col), 32'h0000_0007);
    repeat (4) tick();
    check("col_wrap", 32'(bus.col), 32'h0000_000E);
    run_frames(2);
    check("idle_pulses", 32'(pulses), 32'h0);
    check("idle_value",  32'(bus.value), 32'h0);

    // 2: key 6 (column 1, row 2) held from frame start, select mode.
    pulses  = 0;
    pressed = 16'h0040;
    repeat (31) tick();
    check("k6_no_early_valid", 32'(bus.key_valid), 32'h0);
    tick();
    check("k6_valid", 32'(bus.key_valid), 32'h1);
    check("k6_key",   32'(bus.key),       32'h6);
    check("k6_held",  32'(bus.key_held),  32'h1);
    check("k6_value", 32'(bus.value),     32'h0000_0040);
    tick();
    check("k6_valid_one_cycle", 32'(bus.key_valid), 32'h0);
    repeat (15) tick();
    pressed = 16'h0000;
    run_frames(1);
    check("k6_held_after_1_none", 32'(bus.key_held), 32'h1);
    run_frames(1);
    check("k6_released",      32'(bus.key_held), 32'h0);
    check("k6_value_kept",    32'(bus.value),    32'h0000_0040);
    check("k6_key_kept",      32'(bus.key),      32'h6);
    check("k6_pulse_count",   32'(pulses),       32'h1);

    // 3: toggle mode, keys 3, 3, 9.
    bus.mode  = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_value", 32'(bus.value), 32'h0);
    repeat (15) tick();
    pulses  = 0;
    pressed = 16'h0008;
    run_frames(2);
    check("t3_first_valid", 32'(bus.key_valid), 32'h1);
    check("t3_first_value", 32'(bus.value),     32'h0000_0008);
    pressed = 16'h0000;
    run_frames(2);
    check("t3_first_release", 32'(bus.key_held), 32'h0);
    pressed = 16'h0008;
    run_frames(2);
    check("t3_second_value", 32'(bus.value), 32'h0000_0000);
    pressed = 16'h0000;
    run_frames(2);
    pressed = 16'h0200;
    run_frames(2);
    check("t9_value", 32'(bus.value), 32'h0000_0200);
    check("t9_key",   32'(bus.key),   32'h9);
    pressed = 16'h0000;
    run_frames(2);
    check("toggle_pulse_count", 32'(pulses), 32'h3);

    // Mode change alone leaves value untouched.
    bus.mode = 1'b0;
    run_frames(1);
    check("mode_change_value", 32'(bus.value), 32'h0000_0200);

    // 4: one-frame bounce on key 5, then keys 0 and 15 together.
    pulses  = 0;
    pressed = 16'h0020;
    run_frames(1);
    pressed = 16'h0000;
    run_frames(2);
    pressed = 16'h8001;
    run_frames(4);
    check("multi_not_held", 32'(bus.key_held), 32'h0);
    pressed = 16'h0000;
    run_frames(2);
    check("bounce_pulses", 32'(pulses),    32'h0);
    check("bounce_value",  32'(bus.value), 32'h0000_0200);
    check("bounce_key",    32'(bus.key),   32'h9);

    // 5: clear sampled on the same edge that accepts key 2.
    pulses  = 0;
    pressed = 16'h0004;
    repeat (31) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_acc_valid", 32'(bus.key_valid), 32'h1);
    check("clr_acc_key",   32'(bus.key),       32'h2);
    check("clr_acc_value", 32'(bus.value),     32'h0);
    tick();
    check("clr_acc_value_after", 32'(bus.value), 32'h0);
    repeat (15) tick();
    pressed = 16'h0000;
    run_frames(2);
    check("clr_acc_pulses", 32'(pulses), 32'h1);

    // 6: key 4 held ten frames past acceptance in toggle mode.
    bus.mode = 1'b1;
    pulses   = 0;
    pressed  = 16'h0010;
    run_frames(2);
    check("hold_accept_value", 32'(bus.value), 32'h0000_0010);
    check("hold_accept_key",   32'(bus.key),   32'h4);
    run_frames(10);
    check("hold_value", 32'(bus.value), 32'h0000_0010);
    pressed = 16'h0000;
    run_frames(2);
    check("hold_pulses",        32'(pulses),       32'(HOLD_PULSES));
    check("hold_release_value", 32'(bus.value),    32'h0000_0010);
    check("hold_release_held",  32'(bus.key_held), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_grid_select.md
Name: keypad_grid_select

Overview:
- Parametrised successor to the fixed 4x4 keypad-to-one-hot decoder.
- Scans a ROWS x COLS matrix keypad and debounces over whole scan frames.
- Emits a key index with a single-cycle valid pulse and maintains an N-bit cell vector (N = ROWS*COLS) in one of two modes:
  - select: one-hot of the last key;
  - toggle: accumulating cell marks for battleship grid placement/targeting.

Parameters:
- ROWS, 4, keypad row count (inputs).
- COLS, 4, keypad column count (driven outputs).
- SCAN_DIV, 100000, clk cycles each column is driven before advancing (>=2).
- DEBOUNCE_SCANS, 4, consecutive identical frames required to accept a change (>=1).
- REPEAT_FRAMES, 32, held frames between auto-repeats (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- row  in  ROWS  keypad rows, active-low (0 = pressed in currently driven column).
- col  out  COLS  column drive, active-low one-hot.
- mode  in  1  0 = select (one-hot), 1 = toggle.
- clear  in  1  synchronous clear of value.
- key  out  $clog2(ROWS*COLS)  index of last accepted key, = c*ROWS + r.
- key_valid  out  1  one-cycle pulse on each accepted press.
- key_held  out  1  debounced "a key is down".
- value  out  ROWS*COLS  cell vector.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - div = 0, col_idx = 0, col = ~1 (column 0 driven low);
  - key = 0, key_valid = 0, key_held = 0, value = 0;
  - frame accumulator empty, stable state = NONE, debounce count = 0.
- Reset mid-scan or mid-debounce discards all progress; no key_valid is emitted.
- Scan:
  - div counts 0..SCAN_DIV-1.
  - row is sampled when div == SCAN_DIV-1, which gives settle time.
  - On the next cycle div wraps to 0 and col_idx advances, wrapping COLS-1 -> 0.
  - col = ~(1 << col_idx) always; exactly one column is low.
  - Frame = COLS*SCAN_DIV cycles, ending at the sample of column COLS-1.
- Frame classification, applied to all ROWS*COLS samples of the frame:
  - zero pressed -> NONE;
  - exactly one pressed -> KEY(k);
  - two or more -> MULTI.
- Debounce:
  - If the frame class equals the previous frame class (NONE/KEY with the same k), cnt increments, saturating at DEBOUNCE_SCANS; otherwise cnt = 1.
  - MULTI always sets cnt = 0 and never causes acceptance.
  - When cnt reaches DEBOUNCE_SCANS and the class differs from the stable state, the stable state is updated.
- Stable state change to KEY(k), from NONE or from a different key:
  - In the cycle after the frame-end sample: key <= k, key_valid = 1 for exactly one cycle, key_held = 1.
  - mode 0: value <= 1 << k.
  - mode 1: value <= value ^ (1 << k).
- Stable state change to NONE: key_held <= 0. key and value are held.
- Latency: a press held from the start of frame F is accepted at the end of frame F+DEBOUNCE_SCANS-1, plus 1 cycle.
- clear:
  - value <= 0 in the next cycle.
  - If coincident with an accept, clear wins for value; key and key_valid still update.
- mode is sampled only at accept. Changing mode never alters value by itself.
- Width rule: N = ROWS*COLS; key width = max(1, $clog2(N)).

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - While stable state = KEY(k), a frame counter counts held frames.
  - Every REPEAT_FRAMES frames, key_valid pulses again with key = k.
  - In mode 0, value is rewritten with the same one-hot (no change). In mode 1, value is NOT toggled on repeats.
  - The counter resets on any stable-state change or reset.
- Undefined: exactly one key_valid per accepted press; no repeat logic is synthesised and REPEAT_FRAMES is ignored.

Test Plan:
Bench parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 16 cycles).
1. Reset then idle, all rows high -> col cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never asserts; value=0.
2. Hold row[2] low whenever col[1] is low, starting at frame start -> key=6, one key_valid pulse 33 cycles after frame start; value=16'h0040; key_held=1; release -> key_held=0 after 2 NONE frames, value stays 16'h0040.
3. mode=1: press/release key 3, then key 3 again, then key 9 -> value 16'h0008, then 16'h0000, then 16'h0200; three key_valid pulses.
4. Bounce: a key-5 press lasting 1 frame with NONE on both sides; then keys 0 and 15 pressed together for 4 frames -> no key_valid; value unchanged.
5. clear asserted in the same cycle as the key_valid for key 2 (mode 0) -> key=2, key_valid=1, value=0.
6. With KEYPAD_REPEAT_EN, REPEAT_FRAMES=3, mode=1, key 4 held 10 frames after acceptance -> 1 accept + 3 repeat pulses; value=16'h0010 throughout. Without the macro -> exactly 1 pulse.
